// File: rtl/dfa_seq_pkg.sv
// Shared types and constants for the sequenced trigger controller.
// Field selects address one column of the stage table.
package dfa_seq_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      HOLD
   } state_t;

   localparam logic [1:0] FLD_MASK = 2'b00;
   localparam logic [1:0] FLD_PAT  = 2'b01;
   localparam logic [1:0] FLD_WIN  = 2'b10;
   localparam logic [1:0] FLD_LAST = 2'b11;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_WIN_W  = 16;

endpackage

// File: rtl/dfa_stage_table.sv
// Mask/pattern/window/last register file for the trigger stages.
// One gated write port, combinational read of the selected stage.
module dfa_stage_table
   import dfa_seq_pkg::*;
#(
   parameter int NUM_STAGES = 4,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int WIN_W      = DEF_WIN_W,
   parameter int SEL_W      = $clog2(NUM_STAGES)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [SEL_W+1:0]  wr_addr,
   input  logic [0:DATA_W-1] wr_data,
   input  logic [SEL_W-1:0]  rd_sel,
   output logic [0:DATA_W-1] rd_mask,
   output logic [0:DATA_W-1] rd_pat,
   output logic [WIN_W-1:0]  rd_win,
   output logic              rd_last
);

   logic [0:DATA_W-1] mask_q [NUM_STAGES];
   logic [0:DATA_W-1] pat_q  [NUM_STAGES];
   logic [WIN_W-1:0]  win_q  [NUM_STAGES];
   logic              last_q [NUM_STAGES];

   logic [SEL_W-1:0] wr_idx;
   logic [1:0]       wr_fld;

   assign wr_idx = wr_addr[SEL_W+1:2];
   assign wr_fld = wr_addr[1:0];

   // Bit DATA_W-1 is the least significant bit in MSB-first numbering
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_STAGES; i++) begin
            mask_q[i] <= '0;
            pat_q[i]  <= '0;
            win_q[i]  <= '0;
            last_q[i] <= 1'b0;
         end
      end else if (wr_en) begin
         unique case (wr_fld)
            FLD_MASK: mask_q[wr_idx] <= wr_data;
            FLD_PAT:  pat_q[wr_idx]  <= wr_data;
            FLD_WIN:  win_q[wr_idx]  <= wr_data[DATA_W-WIN_W +: WIN_W];
            FLD_LAST: last_q[wr_idx] <= wr_data[DATA_W-1];
         endcase
      end
   end

   assign rd_mask = mask_q[rd_sel];
   assign rd_pat  = pat_q[rd_sel];
   assign rd_win  = win_q[rd_sel];
   assign rd_last = last_q[rd_sel];

endmodule

// File: rtl/dfa_trigger_sequencer.sv
// Sequenced multi-stage trigger: each stage must match within its
// window; the end stage fires TRIGGER, expiry fires TIMEOUT.
module dfa_trigger_sequencer
   import dfa_seq_pkg::*;
#(
   parameter int NUM_STAGES = 4,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int WIN_W      = DEF_WIN_W,
   parameter int SEL_W      = $clog2(NUM_STAGES)
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              START,
   input  logic              ABORT,
   input  logic [0:DATA_W-1] DATA,
   input  logic              CFG_WE,
   input  logic [SEL_W+1:0]  CFG_ADDR,
   input  logic [0:DATA_W-1] CFG_WDATA,
   output logic              TRIGGER,
   output logic              TIMEOUT,
   output logic              BUSY,
   output logic [SEL_W-1:0]  STAGE,
   output logic              CFG_ERR
);

   state_t            state;
   logic [WIN_W-1:0]  cnt;
   logic [WIN_W-1:0]  cnt_inc;
   logic [0:DATA_W-1] t_mask;
   logic [0:DATA_W-1] t_pat;
   logic [WIN_W-1:0]  t_win;
   logic              t_last;
   logic              wr_en;
   logic              hit;
   logic              is_end;
   logic              expire;

   // Table is frozen outside IDLE so a run never sees a mid-run edit
   assign wr_en = CFG_WE && (state == IDLE);

   dfa_stage_table #(
      .NUM_STAGES(NUM_STAGES),
      .DATA_W    (DATA_W),
      .WIN_W     (WIN_W),
      .SEL_W     (SEL_W)
   ) u_table (
      .clk    (CLK),
      .rst    (RST),
      .wr_en  (wr_en),
      .wr_addr(CFG_ADDR),
      .wr_data(CFG_WDATA),
      .rd_sel (STAGE),
      .rd_mask(t_mask),
      .rd_pat (t_pat),
      .rd_win (t_win),
      .rd_last(t_last)
   );

   assign hit     = ((DATA & t_mask) == (t_pat & t_mask));
   assign is_end  = t_last || (STAGE == SEL_W'(NUM_STAGES - 1));
   assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;
   assign expire  = (t_win != '0) && (cnt_inc == t_win);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state   <= IDLE;
         cnt     <= '0;
         STAGE   <= '0;
         TRIGGER <= 1'b0;
         TIMEOUT <= 1'b0;
         BUSY    <= 1'b0;
         CFG_ERR <= 1'b0;
      end else begin
         TRIGGER <= 1'b0;
         TIMEOUT <= 1'b0;
         CFG_ERR <= CFG_WE && (state != IDLE);
         unique case (state)
            IDLE: begin
               if (START) begin
                  state <= ARMED;
                  STAGE <= '0;
                  cnt   <= '0;
                  BUSY  <= 1'b1;
               end
            end
            ARMED: begin
               if (ABORT) begin
                  state <= IDLE;
                  STAGE <= '0;
                  cnt   <= '0;
                  BUSY  <= 1'b0;
               end else if (hit && is_end) begin
                  state   <= HOLD;
                  TRIGGER <= 1'b1;
                  BUSY    <= 1'b0;
               end else if (hit) begin
                  STAGE <= STAGE + 1'b1;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt_inc;
                  if (expire) begin
                     state   <= HOLD;
                     TIMEOUT <= 1'b1;
                     BUSY    <= 1'b0;
                  end
               end
            end
            HOLD: begin
               if (ABORT) begin
                  state <= IDLE;
                  STAGE <= '0;
               end else if (!START) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
               BUSY  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dfa_trigger_sequencer.sv
// Bench for dfa_trigger_sequencer: directed scenarios plus random
// traffic checked against a behavioural model every cycle.
module tb_dfa_trigger_sequencer;

   localparam int N = 4;

   logic        CLK = 1'b0;
   logic        RST;
   logic        START;
   logic        ABORT;
   logic [0:31] DATA;
   logic        CFG_WE;
   logic [3:0]  CFG_ADDR;
   logic [0:31] CFG_WDATA;
   logic        TRIGGER;
   logic        TIMEOUT;
   logic        BUSY;
   logic [1:0]  STAGE;
   logic        CFG_ERR;

   dfa_trigger_sequencer dut (
      .CLK      (CLK),
      .RST      (RST),
      .START    (START),
      .ABORT    (ABORT),
      .DATA     (DATA),
      .CFG_WE   (CFG_WE),
      .CFG_ADDR (CFG_ADDR),
      .CFG_WDATA(CFG_WDATA),
      .TRIGGER  (TRIGGER),
      .TIMEOUT  (TIMEOUT),
      .BUSY     (BUSY),
      .STAGE    (STAGE),
      .CFG_ERR  (CFG_ERR)
   );

   always #5 CLK = ~CLK;

   int n_cmp = 0;
   int n_bad = 0;

   // model: 0 idle, 1 running, 2 finished-waiting-for-release
   int          m_mode;
   int          m_stage;
   int          m_seen;
   bit          m_stage_known;
   bit          m_trig, m_to, m_err;
   logic [31:0] m_mask [N];
   logic [31:0] m_pat  [N];
   int          m_win  [N];
   bit          m_last [N];
   bit          chk_en = 0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_stage = 0; m_seen = 0; m_stage_known = 1;
      m_trig = 0; m_to = 0; m_err = 0;
      for (int i = 0; i < N; i++) begin
         m_mask[i] = 0; m_pat[i] = 0; m_win[i] = 0; m_last[i] = 0;
      end
   endtask

   task automatic model_step(input bit st, input bit ab, input logic [31:0] d,
                             input bit we, input logic [3:0] a, input logic [31:0] wd);
      int k;
      m_trig = 0; m_to = 0;
      m_err = we && (m_mode != 0);
      case (m_mode)
         0: begin
            if (we) begin
               k = int'(a[3:2]);
               case (a[1:0])
                  2'd0: m_mask[k] = wd;
                  2'd1: m_pat[k] = wd;
                  2'd2: m_win[k] = int'(wd[15:0]);
                  default: m_last[k] = wd[0];
               endcase
            end
            if (st) begin
               m_mode = 1; m_stage = 0; m_seen = 0; m_stage_known = 1;
            end
         end
         1: begin
            k = m_stage;
            if (ab) begin
               m_mode = 0; m_stage = 0;
            end else if (((d ^ m_pat[k]) & m_mask[k]) == 0) begin
               if (m_last[k] || k == N - 1) begin
                  m_trig = 1; m_mode = 2;
               end else begin
                  m_stage = k + 1; m_seen = 0;
               end
            end else begin
               if (m_seen < 65535) m_seen++;
               if (m_win[k] != 0 && m_seen == m_win[k]) begin
                  m_to = 1; m_mode = 2;
               end
            end
         end
         default: begin
            if (ab) begin
               m_mode = 0; m_stage = 0;
            end else if (!st) begin
               m_mode = 0; m_stage_known = 0;
            end
         end
      endcase
   endtask

   always @(negedge CLK) begin
      if (chk_en) begin
         check("TRIGGER", int'(TRIGGER), int'(m_trig));
         check("TIMEOUT", int'(TIMEOUT), int'(m_to));
         check("BUSY", int'(BUSY), int'(m_mode == 1));
         check("CFG_ERR", int'(CFG_ERR), int'(m_err));
         if (m_stage_known) check("STAGE", int'(STAGE), m_stage);
      end
   end

   task automatic cyc(input bit st, input bit ab, input logic [31:0] d,
                      input bit we, input logic [3:0] a, input logic [31:0] wd);
      START = st; ABORT = ab; DATA = d;
      CFG_WE = we; CFG_ADDR = a; CFG_WDATA = wd;
      @(posedge CLK);
      model_step(st, ab, d, we, a, wd);
      #1;
   endtask

   task automatic wr(input int s, input int f, input logic [31:0] wd);
      logic [3:0] a;
      a = {2'(s), 2'(f)};
      cyc(0, 0, 0, 1, a, wd);
   endtask

   task automatic idle_cyc();
      cyc(0, 0, 0, 0, 4'd0, 0);
   endtask

   initial begin
      model_reset();
      RST = 1; START = 0; ABORT = 0; DATA = 0;
      CFG_WE = 0; CFG_ADDR = 0; CFG_WDATA = 0;
      repeat (2) @(posedge CLK);
      #1;
      check("rst_trigger", int'(TRIGGER), 0);
      check("rst_busy", int'(BUSY), 0);
      check("rst_stage", int'(STAGE), 0);
      RST = 0;
      chk_en = 1;

      // two-stage sequence 0x11 then 0x22
      wr(0, 0, 32'hFF); wr(0, 1, 32'h11);
      wr(1, 0, 32'hFF); wr(1, 1, 32'h22); wr(1, 3, 32'h1);
      cyc(1, 0, 0, 0, 0, 0);
      check("arm_busy", int'(BUSY), 1);
      cyc(0, 0, 32'h11, 0, 0, 0);
      check("adv_stage", int'(STAGE), 1);
      cyc(0, 0, 32'h22, 0, 0, 0);
      check("trig_pulse", int'(TRIGGER), 1);
      check("trig_stage", int'(STAGE), 1);
      check("trig_busy", int'(BUSY), 0);
      idle_cyc();
      check("trig_one_cyc", int'(TRIGGER), 0);

      // stage1 window of 3: three misses expire
      wr(1, 2, 32'h3);
      cyc(1, 0, 0, 0, 0, 0);
      cyc(0, 0, 32'h11, 0, 0, 0);
      cyc(0, 0, 32'h00, 0, 0, 0);
      cyc(0, 0, 32'h00, 0, 0, 0);
      check("to_early", int'(TIMEOUT), 0);
      cyc(0, 0, 32'h00, 0, 0, 0);
      check("to_pulse", int'(TIMEOUT), 1);
      check("to_notrig", int'(TRIGGER), 0);
      idle_cyc();

      // third word of the window still counts
      cyc(1, 0, 0, 0, 0, 0);
      cyc(0, 0, 32'h11, 0, 0, 0);
      cyc(0, 0, 32'h00, 0, 0, 0);
      cyc(0, 0, 32'h00, 0, 0, 0);
      cyc(0, 0, 32'h22, 0, 0, 0);
      check("win_edge_trig", int'(TRIGGER), 1);
      check("win_edge_to", int'(TIMEOUT), 0);
      idle_cyc();

      // write while running is rejected
      cyc(1, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 4'b0000, 32'h0);
      check("cfg_err", int'(CFG_ERR), 1);
      cyc(0, 1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);
      cyc(0, 0, 32'h10, 0, 0, 0);
      check("old_mask", int'(STAGE), 0);
      cyc(0, 1, 0, 0, 0, 0);

      // write and arm on the same edge
      cyc(1, 0, 0, 1, 4'b0001, 32'h33);
      cyc(0, 0, 32'h33, 0, 0, 0);
      check("same_edge_wr", int'(STAGE), 1);

      // abort beats a matching word
      cyc(0, 1, 32'h22, 0, 0, 0);
      check("abort_trig", int'(TRIGGER), 0);
      check("abort_stage", int'(STAGE), 0);
      check("abort_busy", int'(BUSY), 0);

      // reset mid-run clears the table
      cyc(1, 0, 0, 0, 0, 0);
      cyc(0, 0, 32'h33, 0, 0, 0);
      #2 RST = 1;
      #1;
      check("amid_busy", int'(BUSY), 0);
      check("amid_stage", int'(STAGE), 0);
      model_reset();
      @(posedge CLK);
      #1 RST = 0;
      cyc(1, 0, 0, 0, 0, 0);
      cyc(0, 0, 32'h44, 0, 0, 0);
      check("cleared_tbl", int'(STAGE), 1);
      cyc(0, 1, 0, 0, 0, 0);

      // random traffic
      for (int i = 0; i < 4000; i++) begin
         logic [3:0]  a;
         logic [31:0] wd;
         logic [31:0] d;
         bit st, ab, we;
         st = ($urandom_range(0, 9) < 6);
         ab = ($urandom_range(0, 39) == 0);
         we = ($urandom_range(0, 6) == 0);
         a = 4'($urandom_range(0, 15));
         case (a[1:0])
            2'd0: wd = 32'($urandom_range(0, 15));
            2'd1: wd = 32'($urandom_range(0, 15));
            2'd2: wd = 32'($urandom_range(0, 6));
            default: wd = $urandom;
         endcase
         d = 32'($urandom_range(0, 15));
         cyc(st, ab, d, we, a, wd);
      end

      chk_en = 0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
